// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory byte-stream loader.
package loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WR,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/inst_loader.sv
// Framed byte-stream loader: assembles LE words, writes them to instruction
// memory, verifies an XOR checksum and holds the core in reset until a good load.
module inst_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        load_we,
    output logic [31:0] load_addr,
    output logic [31:0] load_data,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [7:0]         chk_q, chk_d;
    logic [1:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic               we_d, core_rst_d, done_d, error_d;
    logic [WORD_W-1:0]  laddr_d, ldata_d;
    logic [LEN_W-1:0]   len_w;
    logic               xfer;

    // The only non-accepting state is the write bubble.
    assign in_ready = (state_q != ST_WR);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        left_d  = left_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        laddr_d = load_addr;
        ldata_d = load_data;
        len_w   = {in_data, left_q[7:0]};

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (xfer && in_data == SYNC_BYTE) state_d = ST_LEN0;
            end
            ST_LEN0: begin
                // left_q low byte doubles as LEN_LO storage until LEN_HI arrives
                if (xfer) begin
                    left_d  = LEN_W'(in_data);
                    chk_d   = in_data;
                    state_d = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (xfer) begin
                    left_d = len_w;
                    chk_d  = chk_q ^ in_data;
                    if (32'(len_w) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (len_w == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                        addr_d  = BASE_ADDR;
                        idx_d   = 2'd0;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    word_d[{idx_q, 3'b000} +: 8] = in_data;
                    chk_d = chk_q ^ in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_WR;
                        we_d    = 1'b1;
                        ldata_d = word_d;
                        laddr_d = addr_q;
                    end
                end
            end
            ST_WR: begin
                addr_d  = addr_q + 32'(ADDR_STEP);
                left_d  = left_q - LEN_W'(1);
                state_d = (left_q == LEN_W'(1)) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (xfer) state_d = (in_data == chk_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags follow the destination state so they are registered with it
        core_rst_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            left_q    <= '0;
            addr_q    <= BASE_ADDR;
            load_we   <= 1'b0;
            load_addr <= BASE_ADDR;
            load_data <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            left_q    <= left_d;
            addr_q    <= addr_d;
            load_we   <= we_d;
            load_addr <= laddr_d;
            load_data <= ldata_d;
            core_rst  <= core_rst_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a frame-level model.
module tb_inst_loader;
    import loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        core_rst;
    logic        done;
    logic        error;

    localparam logic [31:0] BASE = 32'h0000_0000;

    inst_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame_q[$];
    int         total = 0;
    int         bad   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
        end
    endfunction

    // Model of a frame: word i lands at BASE+4*i, bytes LSB first, XOR checksum.
    task automatic build_words(input logic [31:0] words[$], input bit bad_chk);
        int n;
        logic [7:0] chk;
        logic [31:0] w;
        n = words.size();
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        chk = 8'(n) ^ 8'(n >> 8);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(w[b*8 +: 8]);
                chk ^= w[b*8 +: 8];
            end
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: w});
        end
        frame_q.push_back(bad_chk ? (chk ^ 8'h01) : chk);
    endtask

    task automatic build_random(input int n, input bit bad_chk);
        logic [31:0] words[$];
        for (int i = 0; i < n; i++) words.push_back($urandom);
        build_words(words, bad_chk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        bit ok;
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) check("ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_frame(input int gap_max);
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], gap_max);
        in_valid = 1'b0;
    endtask

    task automatic check_outcome(input string nm, input bit exp_done, input bit exp_err);
        check({nm, "_done"}, 32'(done), 32'(exp_done));
        check({nm, "_error"}, 32'(error), 32'(exp_err));
        check({nm, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
        check({nm, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        check({nm, "_load_we"}, 32'(load_we), 32'd0);
        check({nm, "_load_addr"}, load_addr, BASE);
        check({nm, "_load_data"}, load_data, 32'd0);
        check({nm, "_core_rst"}, 32'(core_rst), 32'd1);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_error"}, 32'(error), 32'd0);
    endtask

    // Every cycle: stall only on writes, core held unless done, writes match model.
    always @(negedge clk) begin
        wr_t w;
        if (!rst) begin
            check("ready_vs_we", 32'(in_ready), 32'(!load_we));
            check("core_rst_vs_done", 32'(core_rst), 32'(!done));
            if (load_we) begin
                check("we_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("we_addr", load_addr, w.addr);
                    check("we_data", load_data, w.data);
                end
            end
        end
    end

    initial begin
        logic [31:0] words[$];
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Normal load with hand-pinned model values
        words = '{32'h0000_0013, 32'h0010_0093};
        build_words(words, 1'b0);
        check("pin_chk", 32'(frame_q[frame_q.size()-1]), 32'h92);
        check("pin_byte3", 32'(frame_q[3]), 32'h13);
        check("pin_w1_addr", exp_q[1].addr, 32'd4);
        check("pin_w1_data", exp_q[1].data, 32'h0010_0093);
        send_frame(0);
        check_outcome("normal", 1'b1, 1'b0);

        // Bad checksum: writes still happen
        build_words(words, 1'b1);
        send_frame(2);
        check_outcome("badchk", 1'b0, 1'b1);

        // Oversize length 0x0101
        frame_q = '{8'hA5, 8'h01, 8'h01};
        send_frame(1);
        check_outcome("oversize", 1'b0, 1'b1);

        // Zero length
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(1);
        check_outcome("zero", 1'b1, 1'b0);

        // Continuous valid, then random gaps and random checksum faults
        build_random(5, 1'b0);
        send_frame(0);
        check_outcome("stream", 1'b1, 1'b0);
        for (int f = 0; f < 8; f++) begin
            bit bc;
            bc = ($urandom_range(0, 3) == 0);
            build_random($urandom_range(1, 8), bc);
            send_frame(3);
            check_outcome("random", !bc, bc);
        end

        // Reset mid-frame after 6 payload bytes
        build_random(2, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(frame_q[i], 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        build_random(3, 1'b0);
        send_frame(2);
        check_outcome("after_rst", 1'b1, 1'b0);

        // Reload: junk ignored, sync reasserts core reset
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        in_valid = 1'b0;
        check("junk_done", 32'(done), 32'd1);
        build_random(1, 1'b0);
        void'(frame_q.pop_front());
        send_byte(8'hA5, 0);
        check("reload_core_rst", 32'(core_rst), 32'd1);
        check("reload_done_clr", 32'(done), 32'd0);
        send_frame(1);
        check_outcome("reload", 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
